// File: rtl/mono_rx_arb_pkg.sv
// Shared types and defaults for the mono_data_rx FIFO arbiter.
package mono_rx_arb_pkg;

    localparam int WORD_W        = 32;
    localparam int DEF_N_SRC     = 4;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mono_rx_rr_pick.sv
// Round-robin search: first requesting index after ptr, wrapping at N_SRC.
module mono_rx_rr_pick #(
    parameter int N_SRC = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_SRC-1:0] pick,
    output logic             valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (idx == PTR_W'(N_SRC - 1)) ? '0 : idx + 1'b1;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mono_rx_fifo_arbiter.sv
// Round-robin burst arbiter merging mono_data_rx FWFT FIFOs into one
// registered output word for the common readout FIFO.
module mono_rx_fifo_arbiter
    import mono_rx_arb_pkg::*;
#(
    parameter int N_SRC     = DEF_N_SRC,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                      BUS_CLK,
    input  logic                      BUS_RST,
    input  logic [N_SRC-1:0]          SRC_EN,
    input  logic [N_SRC-1:0]          SRC_FIFO_EMPTY,
    input  logic [WORD_W*N_SRC-1:0]   SRC_FIFO_DATA,
    output logic [N_SRC-1:0]          SRC_FIFO_READ,
    input  logic                      FIFO_READ,
    output logic                      FIFO_EMPTY,
    output logic [WORD_W-1:0]         FIFO_DATA,
    output logic [N_SRC-1:0]          GRANT
);

    localparam int PTR_W  = $clog2(N_SRC);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  pick_idx;
    logic [BCNT_W-1:0] bcnt;
    logic [N_SRC-1:0]  req;
    logic [N_SRC-1:0]  pick;
    logic              pick_valid;
    logic              src_ok;
    logic              pop;
    logic              burst_last;
    logic [WORD_W-1:0] src_word;

    assign req = SRC_EN & ~SRC_FIFO_EMPTY;

    mono_rx_rr_pick #(
        .N_SRC (N_SRC),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        src_word = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
            if (ptr == PTR_W'(i)) src_word = SRC_FIFO_DATA[i*WORD_W +: WORD_W];
        end
    end

    // ptr doubles as the granted index while in S_GRANT
    assign src_ok     = SRC_EN[ptr] && !SRC_FIFO_EMPTY[ptr];
    assign pop        = (state == S_GRANT) && src_ok && (bcnt < BCNT_MAX)
                        && (FIFO_EMPTY || FIFO_READ);
    assign burst_last = pop && ((bcnt + 1'b1) == BCNT_MAX);

    assign SRC_FIFO_READ = pop ? (N_SRC'(1) << ptr) : '0;
    assign GRANT         = (state == S_GRANT) ? (N_SRC'(1) << ptr) : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_valid) state_nxt = S_GRANT;
            S_GRANT: if (!src_ok || burst_last || bcnt >= BCNT_MAX) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state <= S_IDLE;
            ptr   <= PTR_W'(N_SRC - 1);
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && pick_valid) begin
                ptr  <= pick_idx;
                bcnt <= '0;
            end else if (pop) begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // A pop overwrites the output word directly, so a same-cycle read never bubbles
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            FIFO_EMPTY <= 1'b1;
            FIFO_DATA  <= '0;
        end else if (pop) begin
            FIFO_EMPTY <= 1'b0;
            FIFO_DATA  <= src_word;
        end else if (FIFO_READ) begin
            FIFO_EMPTY <= 1'b1;
        end
    end

endmodule
